rv4028_bus_ctrl: RTL and testbench

Bus cycle sequencer between the femtorv core's 32-bit memory port and the RV4028 external bus (32-bit address, 16-bit data, active-low strobes, `wait_n` stretching). It splits each 32-bit access into up to two 16-bit bus cycles and selects `mreq_n` or `iorq_n` by address region. It inserts wait states while `wait_n` is low and aborts a cycle that stalls too long. The core stalls on `cpu_rbusy`/`cpu_wbusy`; the top level owns the `data` tristate.

---
 rtl/rv4028_bus_pkg.sv | 24 ++
 rtl/rv4028_bus_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_rv4028_bus_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv4028_bus_pkg.sv
// Shared types and constants for the RV4028 bus cycle sequencer.
// Holds the bus state encoding, the I/O prefix default and the idle strobe levels.
package rv4028_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } bus_state_e;

    localparam logic [3:0] DEFAULT_IO_PREFIX = 4'hF;

    localparam logic       HALF_LO     = 1'b0;
    localparam logic       HALF_HI     = 1'b1;
    localparam logic       STROBE_IDLE = 1'b1;
    localparam logic [1:0] WRM_IDLE    = 2'b11;

    // Lowest 16-bit half with any enabled byte; a read always starts at HALF_LO.
    function automatic logic first_write_half(input logic [3:0] mask);
        return (mask[1:0] != 2'b00) ? HALF_LO : HALF_HI;
    endfunction

endpackage

// File: rtl/rv4028_bus_ctrl.sv
// Splits femtorv 32-bit memory accesses into one or two 16-bit RV4028 bus cycles
// (T1/T2/T3), with wait_n stretching of T2 and abort after MAX_WAIT low samples.
module rv4028_bus_ctrl
    import rv4028_bus_pkg::*;
#(
    parameter logic [3:0]  IO_PREFIX = DEFAULT_IO_PREFIX,
    parameter int unsigned MAX_WAIT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wmask,
    input  logic        cpu_rstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rbusy,
    output logic        cpu_wbusy,
    output logic        bus_timeout,
    output logic [31:0] addr,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in,
    output logic        rd_n,
    output logic        wr_n,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic [1:0]  wrm_n,
    input  logic        wait_n
);

    localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

    // Request handshake: a request (cpu_wmask != 0 or cpu_rstrb) is taken only in
    // IDLE, on the edge that samples it; while cpu_rbusy/cpu_wbusy is high every
    // new request is dropped, and busy falling marks the access as complete.

    bus_state_e  state_q, state_d;
    logic        half_q, half_d;
    logic        is_wr_q, is_wr_d;
    logic        is_io_q, is_io_d;
    logic        abort_q, abort_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [29:0] base_q, base_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic [31:0] addr_q, addr_d;
    logic [15:0] data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rbusy_q, rbusy_d;
    logic        wbusy_q, wbusy_d;
    logic        timeout_q, timeout_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        mreq_n_q, mreq_n_d;
    logic        iorq_n_q, iorq_n_d;
    logic [1:0]  wrm_n_q, wrm_n_d;

    logic        strobe_on;
    logic [1:0]  slice_d;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr[1:0];

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        is_wr_d    = is_wr_q;
        is_io_d    = is_io_q;
        abort_d    = abort_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        base_d     = base_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((cpu_wmask != 4'b0000) || cpu_rstrb) begin
                    state_d = ST_T1;
                    base_d  = cpu_addr[31:2];
                    is_io_d = (cpu_addr[31:28] == IO_PREFIX);
                    abort_d = 1'b0;
                    if (cpu_wmask != 4'b0000) begin
                        is_wr_d = 1'b1;
                        mask_d  = cpu_wmask;
                        wdata_d = cpu_wdata;
                        half_d  = first_write_half(cpu_wmask);
                    end else begin
                        is_wr_d = 1'b0;
                        mask_d  = 4'b0000;
                        half_d  = HALF_LO;
                    end
                end
            end
            ST_T1: begin
                state_d    = ST_T2;
                wait_cnt_d = 16'd0;
            end
            ST_T2: begin
                if (wait_n) begin
                    state_d = ST_T3;
                    if (!is_wr_q) begin
                        if (half_q == HALF_HI) rdata_d[31:16] = data_in;
                        else                   rdata_d[15:0]  = data_in;
                    end
                end else if (wait_cnt_q + 16'd1 == MAX_WAIT_C) begin
                    state_d   = ST_T3;
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_T3: begin
                // An aborted access never runs its second half.
                if (!abort_q && (half_q == HALF_LO) &&
                    (!is_wr_q || (mask_q[3:2] != 2'b00))) begin
                    state_d = ST_T1;
                    half_d  = HALF_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next registered state so every pin is a flop.
        strobe_on = (state_d == ST_T1) || (state_d == ST_T2);
        slice_d   = (half_d == HALF_HI) ? mask_d[3:2] : mask_d[1:0];

        addr_d = addr_q;
        if (state_d == ST_T1) addr_d = {base_d, half_d, 1'b0};

        data_out_d = data_out_q;
        if ((state_d == ST_T1) && is_wr_d)
            data_out_d = (half_d == HALF_HI) ? wdata_d[31:16] : wdata_d[15:0];

        data_oe_d = is_wr_d && (state_d != ST_IDLE);
        mreq_n_d  = !(strobe_on && !is_io_d);
        iorq_n_d  = !(strobe_on && is_io_d);
        rd_n_d    = !((state_d == ST_T2) && !is_wr_d);
        wr_n_d    = !((state_d == ST_T2) && is_wr_d);
        wrm_n_d   = (strobe_on && is_wr_d) ? ~slice_d : WRM_IDLE;
        rbusy_d   = (state_d != ST_IDLE) && !is_wr_d;
        wbusy_d   = (state_d != ST_IDLE) && is_wr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            half_q     <= HALF_LO;
            is_wr_q    <= 1'b0;
            is_io_q    <= 1'b0;
            abort_q    <= 1'b0;
            mask_q     <= 4'b0000;
            wdata_q    <= 32'd0;
            base_q     <= 30'd0;
            wait_cnt_q <= 16'd0;
            addr_q     <= 32'd0;
            data_out_q <= 16'd0;
            data_oe_q  <= 1'b0;
            rdata_q    <= 32'd0;
            rbusy_q    <= 1'b0;
            wbusy_q    <= 1'b0;
            timeout_q  <= 1'b0;
            rd_n_q     <= STROBE_IDLE;
            wr_n_q     <= STROBE_IDLE;
            mreq_n_q   <= STROBE_IDLE;
            iorq_n_q   <= STROBE_IDLE;
            wrm_n_q    <= WRM_IDLE;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            is_wr_q    <= is_wr_d;
            is_io_q    <= is_io_d;
            abort_q    <= abort_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            base_q     <= base_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            rdata_q    <= rdata_d;
            rbusy_q    <= rbusy_d;
            wbusy_q    <= wbusy_d;
            timeout_q  <= timeout_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            mreq_n_q   <= mreq_n_d;
            iorq_n_q   <= iorq_n_d;
            wrm_n_q    <= wrm_n_d;
        end
    end

    assign cpu_rdata   = rdata_q;
    assign cpu_rbusy   = rbusy_q;
    assign cpu_wbusy   = wbusy_q;
    assign bus_timeout = timeout_q;
    assign addr        = addr_q;
    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;
    assign rd_n        = rd_n_q;
    assign wr_n        = wr_n_q;
    assign mreq_n      = mreq_n_q;
    assign iorq_n      = iorq_n_q;
    assign wrm_n       = wrm_n_q;

endmodule

// File: tb/tb_rv4028_bus_ctrl.sv
// Directed bench for rv4028_bus_ctrl: one instance with the default wait limit and
// one with MAX_WAIT=3, selected by sel_b, against a small bus memory model.
module tb_rv4028_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [3:0]  cpu_wmask = 4'd0;
    logic        cpu_rstrb = 1'b0;
    logic        wait_n = 1'b1;
    logic        sel_b = 1'b0;
    logic [15:0] data_in;

    logic [31:0] rdata_a, rdata_b, addr_a, addr_b;
    logic [15:0] dout_a, dout_b;
    logic        rbusy_a, rbusy_b, wbusy_a, wbusy_b, tmo_a, tmo_b, oe_a, oe_b;
    logic        rd_a, rd_b, wr_a, wr_b, mq_a, mq_b, iq_a, iq_b;
    logic [1:0]  wrm_a, wrm_b;

    logic [3:0]  wmask_a, wmask_b;
    logic        rstrb_a, rstrb_b;

    logic [31:0] o_rdata, o_addr;
    logic [15:0] o_dout;
    logic        o_rbusy, o_wbusy, o_tmo, o_oe, o_rd_n, o_wr_n, o_mreq_n, o_iorq_n;
    logic [1:0]  o_wrm_n;

    int total = 0;
    int bad = 0;

    int w_rb, w_wb, w_rdl, w_rdl0, w_wrl, w_mql, w_iql, w_tmo, w_done;
    logic [31:0] w_afirst, w_alast;
    logic [15:0] w_dout;
    logic [1:0]  w_wrm;
    logic [3:0]  w_endstrb;

    always #5 clk = ~clk;

    assign wmask_a = sel_b ? 4'd0 : cpu_wmask;
    assign wmask_b = sel_b ? cpu_wmask : 4'd0;
    assign rstrb_a = cpu_rstrb & ~sel_b;
    assign rstrb_b = cpu_rstrb & sel_b;

    assign o_rdata  = sel_b ? rdata_b : rdata_a;
    assign o_addr   = sel_b ? addr_b  : addr_a;
    assign o_dout   = sel_b ? dout_b  : dout_a;
    assign o_rbusy  = sel_b ? rbusy_b : rbusy_a;
    assign o_wbusy  = sel_b ? wbusy_b : wbusy_a;
    assign o_tmo    = sel_b ? tmo_b   : tmo_a;
    assign o_oe     = sel_b ? oe_b    : oe_a;
    assign o_rd_n   = sel_b ? rd_b    : rd_a;
    assign o_wr_n   = sel_b ? wr_b    : wr_a;
    assign o_mreq_n = sel_b ? mq_b    : mq_a;
    assign o_iorq_n = sel_b ? iq_b    : iq_a;
    assign o_wrm_n  = sel_b ? wrm_b   : wrm_a;

    // Bus-side memory contents returned on data_in.
    always_comb begin
        case (o_addr)
            32'h0000_1000: data_in = 16'hBEEF;
            32'h0000_1002: data_in = 16'hCAFE;
            32'h0000_2000: data_in = 16'h5555;
            32'h0000_2002: data_in = 16'hAAAA;
            32'h0000_3000: data_in = 16'h1357;
            32'h0000_3002: data_in = 16'h2468;
            default:       data_in = 16'h0000;
        endcase
    end

    rv4028_bus_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(wmask_a), .cpu_rstrb(rstrb_a), .cpu_rdata(rdata_a),
        .cpu_rbusy(rbusy_a), .cpu_wbusy(wbusy_a), .bus_timeout(tmo_a),
        .addr(addr_a), .data_out(dout_a), .data_oe(oe_a), .data_in(data_in),
        .rd_n(rd_a), .wr_n(wr_a), .mreq_n(mq_a), .iorq_n(iq_a),
        .wrm_n(wrm_a), .wait_n(wait_n)
    );

    rv4028_bus_ctrl #(.MAX_WAIT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(wmask_b), .cpu_rstrb(rstrb_b), .cpu_rdata(rdata_b),
        .cpu_rbusy(rbusy_b), .cpu_wbusy(wbusy_b), .bus_timeout(tmo_b),
        .addr(addr_b), .data_out(dout_b), .data_oe(oe_b), .data_in(data_in),
        .rd_n(rd_b), .wr_n(wr_b), .mreq_n(mq_b), .iorq_n(iq_b),
        .wrm_n(wrm_b), .wait_n(wait_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Caller has driven a request at a negedge; observe the access until busy falls.
    // wait_n is held low for the first wait_lows T2 samples of the access.
    task automatic watch(input int wait_lows);
        int t2;
        bit seen;
        int first_strb, first_wr;
        t2 = 0; seen = 0; first_strb = 1; first_wr = 1;
        w_rb = 0; w_wb = 0; w_rdl = 0; w_rdl0 = 0; w_wrl = 0; w_mql = 0; w_iql = 0;
        w_tmo = 0; w_done = 0; w_afirst = 32'd0; w_alast = 32'd0; w_dout = 16'd0;
        w_wrm = 2'b11; w_endstrb = 4'd0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            cpu_rstrb = 1'b0;
            cpu_wmask = 4'd0;
            if (o_rbusy || o_wbusy) begin
                seen = 1;
            end else if (seen) begin
                w_done = 1;
                w_endstrb = {o_rd_n, o_wr_n, o_mreq_n, o_iorq_n};
                wait_n = 1'b1;
                break;
            end
            if (o_rbusy) w_rb++;
            if (o_wbusy) w_wb++;
            if (o_tmo) w_tmo++;
            if (!o_mreq_n) w_mql++;
            if (!o_iorq_n) w_iql++;
            if (!o_rd_n) begin
                w_rdl++;
                if (o_addr[1] == 1'b0) w_rdl0++;
            end
            if (!o_wr_n) begin
                w_wrl++;
                if (first_wr == 1) begin
                    w_dout = o_dout;
                    w_wrm = o_wrm_n;
                    first_wr = 0;
                end
            end
            if (!o_mreq_n || !o_iorq_n) begin
                if (first_strb == 1) begin
                    w_afirst = o_addr;
                    first_strb = 0;
                end
                w_alast = o_addr;
            end
            if (!o_rd_n || !o_wr_n) begin
                t2++;
                wait_n = (t2 > wait_lows);
            end else begin
                wait_n = 1'b1;
            end
        end
        chk("access_completes", 32'(w_done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_addr", addr_a, 32'd0);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_busy_tmo_oe", {29'd0, rbusy_a, wbusy_a, tmo_a}, 32'd0);
        chk("rst_strobes", {28'd0, rd_a, wr_a, mq_a, iq_a}, 32'hF);
        chk("rst_wrm_oe_dout", {13'd0, wrm_a, oe_a, dout_a}, {13'd0, 2'b11, 1'b0, 16'h0000});
        rst_n = 1'b1;
        @(negedge clk);

        // Plain two-half read
        cpu_addr = 32'h0000_1000; cpu_rstrb = 1'b1;
        watch(0);
        chk("rd_busy_cycles", 32'(w_rb), 32'd6);
        chk("rd_addr_first", w_afirst, 32'h0000_1000);
        chk("rd_addr_last", w_alast, 32'h0000_1002);
        chk("rd_mreq_low", 32'(w_mql), 32'd4);
        chk("rd_iorq_low", 32'(w_iql), 32'd0);
        chk("rd_rd_low", 32'(w_rdl), 32'd2);
        chk("rd_data", o_rdata, 32'hCAFE_BEEF);
        chk("rd_end_strobes", {28'd0, w_endstrb}, 32'hF);

        // I/O write of the upper half only
        cpu_addr = 32'hF000_0010; cpu_wdata = 32'h1234_5678; cpu_wmask = 4'b1100;
        watch(0);
        chk("io_wbusy", 32'(w_wb), 32'd3);
        chk("io_addr", w_afirst, 32'hF000_0012);
        chk("io_iorq_low", 32'(w_iql), 32'd2);
        chk("io_mreq_low", 32'(w_mql), 32'd0);
        chk("io_dout", {16'd0, w_dout}, 32'h0000_1234);
        chk("io_wrm", {30'd0, w_wrm}, 32'd0);
        chk("io_wr_low", 32'(w_wrl), 32'd1);
        chk("io_oe_after", {31'd0, o_oe}, 32'd0);

        // Single-byte write in the low half
        cpu_addr = 32'h0000_0020; cpu_wdata = 32'hAABB_CCDD; cpu_wmask = 4'b0001;
        watch(0);
        chk("b0_wbusy", 32'(w_wb), 32'd3);
        chk("b0_addr", w_alast, 32'h0000_0020);
        chk("b0_wrm", {30'd0, w_wrm}, 32'b10);
        chk("b0_dout", {16'd0, w_dout}, 32'h0000_CCDD);

        // Read with four wait states in the first T2
        cpu_addr = 32'h0000_2000; cpu_rstrb = 1'b1;
        watch(4);
        chk("ws_busy_cycles", 32'(w_rb), 32'd10);
        chk("ws_rd_low_half0", 32'(w_rdl0), 32'd5);
        chk("ws_rd_low_total", 32'(w_rdl), 32'd6);
        chk("ws_data", o_rdata, 32'hAAAA_5555);

        // Timeout on the MAX_WAIT=3 instance, wait_n low throughout T2
        sel_b = 1'b1;
        cpu_addr = 32'h0000_3000; cpu_rstrb = 1'b1;
        watch(1000);
        chk("to_pulses", 32'(w_tmo), 32'd1);
        chk("to_busy_cycles", 32'(w_rb), 32'd5);
        chk("to_rd_low", 32'(w_rdl), 32'd3);
        chk("to_half1_skipped", w_alast, 32'h0000_3000);
        chk("to_rdata_unchanged", o_rdata, 32'd0);
        chk("to_end_strobes", {28'd0, w_endstrb}, 32'hF);
        chk("to_pulse_cleared", {31'd0, o_tmo}, 32'd0);
        sel_b = 1'b0;

        // Write wins over a simultaneous read strobe
        cpu_addr = 32'h0000_4000; cpu_wdata = 32'hDEAD_BEEF;
        cpu_wmask = 4'b1111; cpu_rstrb = 1'b1;
        watch(0);
        chk("wr_rstrb_rbusy", 32'(w_rb), 32'd0);
        chk("wr_rstrb_wbusy", 32'(w_wb), 32'd6);
        chk("wr_rstrb_wr_low", 32'(w_wrl), 32'd2);
        chk("wr_rstrb_addr_last", w_alast, 32'h0000_4002);
        chk("wr_rstrb_dout0", {16'd0, w_dout}, 32'h0000_BEEF);
        chk("wr_rstrb_rdata_kept", o_rdata, 32'hAAAA_5555);

        // Asynchronous reset in the middle of a stretched T2
        cpu_addr = 32'h0000_5000; cpu_wdata = 32'h0102_0304; cpu_wmask = 4'b1111;
        @(negedge clk);
        cpu_wmask = 4'd0; wait_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_t2", {31'd0, o_wr_n}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {28'd0, o_rd_n, o_wr_n, o_mreq_n, o_iorq_n}, 32'hF);
        chk("rst_mid_busy", {30'd0, o_rbusy, o_wbusy}, 32'd0);
        chk("rst_mid_oe_wrm", {29'd0, o_oe, o_wrm_n}, 32'b011);
        chk("rst_mid_rdata", o_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; wait_n = 1'b1;
        @(negedge clk);

        // Recovery read after reset
        cpu_addr = 32'h0000_1000; cpu_rstrb = 1'b1;
        watch(0);
        chk("post_rst_busy", 32'(w_rb), 32'd6);
        chk("post_rst_data", o_rdata, 32'hCAFE_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
